// File: rtl/mul_pkg.sv
// Shared definitions for the radix-4 sequential multiplier: state and digit
// encodings plus helpers that derive product, digit-count and counter widths.
package mul_pkg;

  localparam int A_WIDTH_DEF = 4;
  localparam int B_WIDTH_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  localparam logic [1:0] DIG_ZERO  = 2'b00;
  localparam logic [1:0] DIG_ONE   = 2'b01;
  localparam logic [1:0] DIG_TWO   = 2'b10;
  localparam logic [1:0] DIG_THREE = 2'b11;

  function automatic int p_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  function automatic int digits(input int b_w);
    return b_w / 2;
  endfunction

  // A single-digit multiplier would need a zero-width counter; keep one bit.
  function automatic int cnt_width(input int d);
    return (d <= 1) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/mul_radix4_seq_if.sv
// Start/done handshake and operand/result bus of the radix-4 multiplier.
interface mul_radix4_seq_if #(
  parameter int A_WIDTH = 4,
  parameter int B_WIDTH = 8
);
  logic                       iStart;
  logic [A_WIDTH-1:0]         iA;
  logic [B_WIDTH-1:0]         iB;
  logic                       oBusy;
  logic                       oDone;
  logic [A_WIDTH+B_WIDTH-1:0] oResult;

  modport master (output iStart, iA, iB, input oBusy, oDone, oResult);
  modport slave  (input iStart, iA, iB, output oBusy, oDone, oResult);
endinterface

// File: rtl/mul_pp_select.sv
// Radix-4 partial-product selector: maps a 2-bit digit of B to 0, A, 2A or 3A.
module mul_pp_select
  import mul_pkg::*;
#(
  parameter int A_WIDTH = A_WIDTH_DEF
) (
  input  logic [A_WIDTH-1:0] a_i,
  input  logic [1:0]         digit_i,
  output logic [A_WIDTH+1:0] pp_o
);

  logic [A_WIDTH+1:0] a_x1;
  logic [A_WIDTH+1:0] a_x2;

  assign a_x1 = {2'b00, a_i};
  assign a_x2 = {1'b0, a_i, 1'b0};

  always_comb begin
    pp_o = '0;
    case (digit_i)
      DIG_ZERO:  pp_o = '0;
      DIG_ONE:   pp_o = a_x1;
      DIG_TWO:   pp_o = a_x2;
      DIG_THREE: pp_o = a_x1 + a_x2;
      default:   pp_o = '0;
    endcase
  end

endmodule

// File: rtl/mul_radix4_seq.sv
// Sequential radix-4 shift-and-add multiplier with start/done handshake.
// Optional MUL_EARLY_EXIT_EN finishes as soon as the remaining B digits are zero.
module mul_radix4_seq
  import mul_pkg::*;
#(
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int B_WIDTH = B_WIDTH_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  mul_radix4_seq_if.slave  bus
);

  localparam int P_WIDTH = p_width(A_WIDTH, B_WIDTH);
  localparam int DIGITS  = digits(B_WIDTH);
  localparam int CW      = cnt_width(DIGITS);
  localparam logic [CW-1:0] K_LAST = CW'(DIGITS - 1);

  state_t             state_q;
  logic [A_WIDTH-1:0] a_q;
  logic [B_WIDTH-1:0] b_q, b_d;
  logic [P_WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      k_q, k_d;
  logic [P_WIDTH-1:0] result_q;
  logic               busy_q;
  logic               done_q;
  logic [A_WIDTH+1:0] pp;
  logic               finish;

  mul_pp_select #(.A_WIDTH(A_WIDTH)) u_pp_select (
    .a_i     (a_q),
    .digit_i (b_q[1:0]),
    .pp_o    (pp)
  );

  // Digit k carries weight 4^k, so the selected multiple is shifted by 2k.
  assign acc_d = acc_q + (P_WIDTH'(pp) << {k_q, 1'b0});
  assign b_d   = b_q >> 2;
  assign k_d   = k_q + CW'(1);

`ifdef MUL_EARLY_EXIT_EN
  assign finish = (k_q == K_LAST) || (b_d == '0);
`else
  assign finish = (k_q == K_LAST);
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      k_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.iStart) begin
            a_q     <= bus.iA;
            b_q     <= bus.iB;
            acc_q   <= '0;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          b_q   <= b_d;
          k_q   <= k_d;
          if (finish) begin
            result_q <= acc_d;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.oBusy   = busy_q;
  assign bus.oDone   = done_q;
  assign bus.oResult = result_q;

endmodule

// File: tb/tb_mul_radix4_seq.sv
// Scoreboard bench for mul_radix4_seq: random and directed products checked
// against plain a*b with the expected completion cycle for the active build.
module tb_mul_radix4_seq;

  localparam int AW     = 4;
  localparam int BW     = 8;
  localparam int DIGITS = BW / 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mul_radix4_seq_if #(.A_WIDTH(AW), .B_WIDTH(BW)) bus ();

  mul_radix4_seq #(.A_WIDTH(AW), .B_WIDTH(BW)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint prod;
    longint cyc;
  } exp_t;

  exp_t        sbq[$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  longint      cyc   = 0;
  logic [AW+BW-1:0] prev_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string nm, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endfunction

  // Edges from acceptance to the edge that enters DONE.
  function automatic longint exp_lat(input int unsigned b);
`ifdef MUL_EARLY_EXIT_EN
    int hi = 0;
    for (int i = 0; i < DIGITS; i++)
      if (((b >> (2 * i)) & 3) != 0) hi = i;
    return longint'(hi + 1);
`else
    return longint'(DIGITS);
`endif
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_res = bus.oResult;
    end else begin
      if (bus.oDone) begin
        if (sbq.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("result", longint'(bus.oResult), e.prod);
          check("done_cycle", cyc, e.cyc);
        end
      end else begin
        check("result_hold", longint'(bus.oResult), longint'(prev_res));
      end
      prev_res = bus.oResult;
    end
  end

  task automatic do_start(input int unsigned a, input int unsigned b);
    int guard = 0;
    while (bus.oBusy && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (bus.oBusy) begin
      check("start_wait_timeout", 1, 0);
      return;
    end
    bus.iA     = AW'(a);
    bus.iB     = BW'(b);
    bus.iStart = 1'b1;
    @(posedge clk);
    sbq.push_back('{longint'(a * b), cyc + 1 + exp_lat(b)});
    #1;
    bus.iStart = 1'b0;
    bus.iA     = AW'($urandom);
    bus.iB     = BW'($urandom);
  endtask

  task automatic drain();
    int guard = 0;
    while (sbq.size() != 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_pending", longint'(sbq.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, pending=%0d", sbq.size());
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iStart = 1'b0;
    bus.iA     = '0;
    bus.iB     = '0;
    #2 rst = 1'b1;
    #2;
    check("reset_busy", longint'(bus.oBusy), 0);
    check("reset_done", longint'(bus.oDone), 0);
    check("reset_result", longint'(bus.oResult), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Directed corner products
    do_start(15, 255);
    drain();
    do_start(9, 6);
    drain();
    do_start(7, 0);
    drain();

    // Start requests while busy must not disturb the running product
    do_start(5, 8'hB7);
    bus.iStart = 1'b1;
    bus.iA     = 4'd12;
    bus.iB     = 8'd99;
    repeat (2) @(posedge clk);
    #1 bus.iStart = 1'b0;
    drain();

    // Back-to-back: second start issued in the DONE cycle of the first
    do_start(3, 5);
    do_start(2, 200);
    drain();

    for (int i = 0; i < 40; i++) begin
      int unsigned a, b;
      a = $urandom_range(0, 15);
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(0, 3);
        1:       b = $urandom_range(0, 15);
        default: b = $urandom_range(0, 255);
      endcase
      do_start(a, b);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    drain();

    // Asynchronous abort in the middle of a product
    do_start(15, 255);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_busy", longint'(bus.oBusy), 0);
    check("abort_done", longint'(bus.oDone), 0);
    check("abort_result", longint'(bus.oResult), 0);
    sbq.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("post_abort_busy", longint'(bus.oBusy), 0);
    do_start(11, 8'h9C);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
